// File: rtl/qpu_exu_evq_pkg.sv
// rtl/qpu_exu_evq_pkg.sv - shared widths, depth and FSM encoding for the timed event queue
package qpu_exu_evq_pkg;

  localparam int QPU_EVENT_WIRE_WIDTH = 16;
  localparam int QPU_EVENT_NUM        = 4;
  localparam int QPU_TIME_WIDTH       = 8;
  localparam int QPU_EVQ_DEPTH        = 8;

  typedef enum logic {
    QPU_EVQ_ST_IDLE = 1'b0,
    QPU_EVQ_ST_RUN  = 1'b1
  } evq_state_e;

  // Queue entry is packed as {edata, oprand, tdata}.
  function automatic int evq_entry_width(input int ew, input int on, input int tw);
    return ew + on + tw;
  endfunction

endpackage

// File: rtl/qpu_evq_fifo.sv
// rtl/qpu_evq_fifo.sv - synchronous FIFO with flush, occupancy count and registered head
module qpu_evq_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 28,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    cnt_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q, rptr_nxt;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  // Qualify requests so the pointers never run past the stored data.
  always_comb begin
    full_o   = (cnt_q == CW'(DEPTH));
    empty_o  = (cnt_q == '0);
    push_ok  = push_i & ~full_o & ~flush_i;
    pop_ok   = pop_i & ~empty_o & ~flush_i;
    rptr_nxt = rptr_q + 1'b1;
  end

  // Storage array; contents are only meaningful between rptr and wptr, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Next head: a push into a queue that is (or becomes) empty lands directly in the head register.
  always_comb begin
    head_d = head_q;
    if (push_ok && (empty_o || (pop_ok && cnt_q == CW'(1)))) begin
      head_d = wdata_i;
    end else if (pop_ok) begin
      head_d = mem_q[rptr_nxt];
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      if (push_ok) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_q <= rptr_nxt;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o = head_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/qpu_exu_evq.sv
// rtl/qpu_exu_evq.sv - timed event queue with timeline counter; optional late drop via QPU_EVQ_LATE_CHECK_EN
module qpu_exu_evq
  import qpu_exu_evq_pkg::*;
#(
  parameter  int DEPTH = QPU_EVQ_DEPTH,
  parameter  int EW    = QPU_EVENT_WIRE_WIDTH,
  parameter  int ON    = QPU_EVENT_NUM,
  parameter  int TW    = QPU_TIME_WIDTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          evq_i_valid,
  output logic          evq_i_ready,
  input  logic [EW-1:0] evq_i_edata,
  input  logic [ON-1:0] evq_i_oprand,
  input  logic [TW-1:0] evq_i_tdata,
  input  logic          evq_i_start,
  input  logic          evq_i_stop,
  output logic [TW-1:0] evq_o_time,
  output logic          evq_o_valid,
  output logic [EW-1:0] evq_o_edata,
  output logic [ON-1:0] evq_o_oprand,
  output logic [CW-1:0] evq_o_cnt,
  output logic          evq_o_late
);

  localparam int WW = evq_entry_width(EW, ON, TW);

  evq_state_e    state_q, state_d;
  logic [TW-1:0] time_q, time_d;
  logic [TW-1:0] t_next;
  logic          disp_en;
  logic          flush;

  logic [WW-1:0] head;
  logic [TW-1:0] head_tdata;
  logic [ON-1:0] head_oprand;
  logic [EW-1:0] head_edata;
  logic          fifo_full, fifo_empty;
  logic          push, pop, hit, head_late;

  logic          valid_q;
  logic [EW-1:0] edata_q;
  logic [ON-1:0] oprand_q;

  assign head_tdata  = head[TW-1:0];
  assign head_oprand = head[TW+ON-1:TW];
  assign head_edata  = head[WW-1:TW+ON];

  assign evq_i_ready = ~fifo_full & ~rst;
  assign push        = evq_i_valid & evq_i_ready;

  qpu_evq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i ({evq_i_edata, evq_i_oprand, evq_i_tdata}),
    .pop_i   (pop),
    .head_o  (head),
    .cnt_o   (evq_o_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Run/idle control: stop beats start, and t_next is the timeline value of the next cycle.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    t_next  = '0;
    disp_en = 1'b0;
    flush   = 1'b0;
    case (state_q)
      QPU_EVQ_ST_IDLE: begin
        if (evq_i_stop) begin
          flush = 1'b1;
        end else if (evq_i_start) begin
          state_d = QPU_EVQ_ST_RUN;
          disp_en = 1'b1;
          t_next  = '0;
          time_d  = '0;
        end
      end
      QPU_EVQ_ST_RUN: begin
        if (evq_i_stop) begin
          state_d = QPU_EVQ_ST_IDLE;
          time_d  = '0;
          flush   = 1'b1;
        end else begin
          t_next  = time_q + 1'b1;
          time_d  = t_next;
          disp_en = 1'b1;
        end
      end
      default: begin
        state_d = QPU_EVQ_ST_IDLE;
        time_d  = '0;
      end
    endcase
  end

  // FSM state and timeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= QPU_EVQ_ST_IDLE;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
    end
  end

  assign hit = disp_en & ~fifo_empty & (head_tdata == t_next);

`ifdef QPU_EVQ_LATE_CHECK_EN
  logic [TW-1:0] head_gap;
  logic          late_q;

  // A head whose distance to t_next is "negative" (MSB set) can never fire on time.
  always_comb begin
    head_gap  = head_tdata - t_next;
    head_late = disp_en & ~fifo_empty & head_gap[TW-1];
  end

  // Sticky late flag; only reset clears it, stop leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      late_q <= 1'b0;
    end else if (head_late) begin
      late_q <= 1'b1;
    end
  end

  assign evq_o_late = late_q;
`else
  assign head_late  = 1'b0;
  assign evq_o_late = 1'b0;
`endif

  assign pop = hit | head_late;

  // Fire register: strobe lands in the cycle the timeline equals the popped tdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      edata_q  <= '0;
      oprand_q <= '0;
    end else begin
      valid_q <= hit;
      if (hit) begin
        edata_q  <= head_edata;
        oprand_q <= head_oprand;
      end
    end
  end

  assign evq_o_time   = time_q;
  assign evq_o_valid  = valid_q;
  assign evq_o_edata  = edata_q;
  assign evq_o_oprand = oprand_q;

endmodule

// File: doc/qpu_exu_evq.md
# qpu_exu_evq

Timed event queue directly downstream of the QIU stage. Buffers write-back events (edata, oprand, tdata) from the QIU in arrival order. Owns the free-running quantum timeline counter and fires each event to the AWG/measurement front end in the exact cycle the timeline equals its timestamp. The counter value is also exported back upstream as the QIU time base (`qiu_i_clk`).

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, ≥2.
- `EW`, `` `QPU_EVENT_WIRE_WIDTH ``: event data width.
- `ON`, `` `QPU_EVENT_NUM ``: operand-mask width.
- `TW`, `` `QPU_TIME_WIDTH ``: timestamp/timeline width.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `evq_i_valid`, in, 1: write-back event valid (from `qiu_o_valid`).
- `evq_i_ready`, out, 1: queue can accept (to `qiu_o_ready`).
- `evq_i_edata`, in, EW: event data.
- `evq_i_oprand`, in, ON: event operand mask.
- `evq_i_tdata`, in, TW: absolute fire time.
- `evq_i_start`, in, 1: pulse; start the timeline.
- `evq_i_stop`, in, 1: pulse; stop, clear timeline, flush queue.
- `evq_o_time`, out, TW: current timeline value.
- `evq_o_valid`, out, 1: one-cycle fire strobe.
- `evq_o_edata`, out, EW: fired event data.
- `evq_o_oprand`, out, ON: fired operand mask.
- `evq_o_cnt`, out, $clog2(DEPTH)+1: occupied entries.
- `evq_o_late`, out, 1: sticky late-event flag (macro only; otherwise tied 0).

## Operation
- FSM with two states:
  - IDLE: reset state; timeline held at 0; enqueue allowed; no dispatch.
  - RUN: timeline increments by 1 every cycle, mod 2^TW (wraps TW'h max → 0).
- Transitions:
  - IDLE→RUN on `evq_i_start`.
  - RUN→IDLE on `evq_i_stop`; the stop cycle also resets the timeline to 0 and flushes the queue (cnt→0, late kept).
  - start and stop in the same cycle: stop wins.
  - start while in RUN: ignored.
- Enqueue: on `evq_i_valid & evq_i_ready`, write {edata, oprand, tdata} at the tail. `evq_i_ready = (cnt != DEPTH) & ~rst`. No bypass when full.
- Target time `t_next`: the value the timeline holds next cycle.
  - IDLE with start (and no stop): 0.
  - RUN without stop: timeline+1 mod 2^TW.
  - All other cases: no dispatch this cycle.
- Dispatch: if the queue is non-empty and head.tdata == `t_next`, pop the head and register it to the outputs with `evq_o_valid`=1 next cycle. At most one pop per cycle.
- Timestamps must be strictly increasing. Events sharing a time are already merged upstream into one edata/oprand word.
- Simultaneous enqueue and pop in the same cycle: both take effect; cnt is unchanged.
- Outputs `evq_o_edata`/`evq_o_oprand` hold their last value when `evq_o_valid`=0.

## Timing
- Reset values: valid 0, edata 0, oprand 0, time 0, cnt 0, late 0, state IDLE. `evq_i_ready` is 0 while `rst` is high and 1 in the first cycle after.
- Enqueue-to-head latency: 1 cycle. An entry written in cycle N is eligible for the comparison in cycle N+1.
- Fire alignment: `evq_o_valid` is high exactly in the cycle where `evq_o_time` == tdata.
- Reset mid-RUN: all state clears in the next cycle, and no strobe is emitted from that cycle on.

## Configuration
- `QPU_EVQ_LATE_CHECK_EN` defined:
  - A head entry is late when the MSB of (head.tdata − `t_next`), computed mod 2^TW, is 1, i.e. the entry is behind the timeline by less than half the timeline range.
  - A late head is popped without a strobe, and `evq_o_late` is set.
  - `evq_o_late` is sticky until `rst`; `evq_i_stop` does not clear it.
- Macro undefined:
  - No late logic; `evq_o_late` is tied 0.
  - A stale head waits until the timeline wraps around and equals its tdata.

## Structure
- Constants go in `QPU_defines.v`: `QPU_EVQ_DEPTH`, `QPU_EVQ_ST_IDLE`, `QPU_EVQ_ST_RUN`. The entry width is EW+ON+TW.
- One sub-module, `qpu_evq_fifo`: a generic synchronous FIFO with push/pop/flush/cnt, one-cycle write-to-read latency, and a registered head output.
- The FSM, timeline counter, comparator and output register live in the top module.

## Test plan
- Reset, enqueue {tdata=5, oprand=1}, start in cycle 0 → `evq_o_valid`=1 only in the cycle where `evq_o_time`=5; edata matches.
- Fill 8 entries in IDLE → `evq_i_ready`=0 and cnt=8; a 9th valid is held. Start → entries fire at their times and ready returns to 1 after the first pop.
- Enqueue and pop in the same cycle with cnt=3 → cnt stays 3, and order is preserved.
- With `QPU_EVQ_LATE_CHECK_EN`: enqueue tdata=2 when the timeline is 10 → no strobe, entry dropped, `evq_o_late`=1 and still set after stop.
- TW wrap: set tdata=2^TW−1, then tdata=1 → both fire, on consecutive wraps of the timeline with no late flag.
- Stop asserted with cnt=4 in the same cycle as start → state stays IDLE, cnt=0, time=0.
